simple_timer: RTL and testbench
===============================

Name: simple_timer

Overview:
Programmable one-shot down-counting timer. A single-cycle `preset` strobe loads a count value. The block then counts down one step per clock and raises a one-cycle `time_out` pulse when the interval expires. It is used as a generic delay/timeout primitive by control logic that needs "N cycles from now" events.

Parameters:
- WIDTH, 8, bit width of the preset value and internal down-counter.

Ports:
- clk, input, 1, rising-edge clock; all state updates on posedge.
- rst, input, 1, asynchronous active-low reset (rst=0 resets immediately, independent of clk).
- preset, input, 1, load strobe, sampled on posedge clk; level-sensitive; each sampled-high edge is a load.
- preset_val, input, WIDTH, count value loaded when preset is sampled high; ignored otherwise.
- time_out, output, 1, registered expiry pulse, high for exactly one clk cycle.

Behaviour:
- State: two-state FSM (IDLE, COUNT), a WIDTH-bit register `count`, and a registered `time_out`.
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, time_out=0.
  - Values hold while rst=0.
  - preset is ignored while rst=0.
- Load rule (any state, priority over everything else on that edge):
  - On a posedge with preset=1: count <= preset_val, state <= COUNT, time_out <= 0.
- COUNT behaviour on a posedge with preset=0:
  - If count != 0: count <= count-1; time_out <= 0.
  - If count == 0: time_out <= 1; state <= IDLE; count stays 0.
- IDLE behaviour on a posedge with preset=0:
  - count holds, time_out <= 0.
  - No pulse is ever generated from IDLE.
- Latency:
  - Load occurs at edge k with value N (preset=0 afterwards).
  - count reaches 0 at edge k+N.
  - time_out is 1 from edge k+N+1 until edge k+N+2.
  - Total delay from load edge to pulse edge is N+1 cycles.
- Boundary: preset_val=0 → time_out pulses at edge k+1 (one-cycle delay).
- Boundary: preset_val=2^WIDTH-1 → counts the full range, no wrap; the counter never decrements below 0.
- Re-preset during COUNT: the timer restarts with the new value; the pending expiry is cancelled; no pulse for the old interval.
- Preset on the same edge as the expiry condition (COUNT, count==0): the load wins, time_out stays 0, and the new interval starts.
- Preset held high across several edges: reloads each of those edges; countdown begins after the first edge with preset=0.
- Preset on the edge where time_out is being driven high from the previous cycle: that pulse still completes its single cycle (time_out drops at that edge per the load rule), and the new interval proceeds normally.
- Reset asserted mid-count: counting aborts, time_out forced to 0 immediately. After reset release the block sits in IDLE until the next preset.
- time_out is never high for two consecutive cycles.
- No X-propagation: preset_val is only sampled when preset=1.

Test Plan:
- Reset:
  - Stimulus: rst=0 for 5 cycles, preset toggling.
  - Required: time_out=0 throughout; no pulse after release without a new preset.
- Basic countdown:
  - Stimulus: load preset_val=5 at edge k.
  - Required: time_out=1 only between edges k+6 and k+7; 0 elsewhere; back to IDLE with no further pulses.
- Zero / max values:
  - Stimulus: load preset_val=0.
  - Required: pulse at edge k+1.
  - Stimulus: load preset_val=255 (WIDTH=8).
  - Required: pulse at edge k+256, no wrap.
- Restart:
  - Stimulus: load 10 at edge k, then load 3 at edge k+4.
  - Required: single pulse at edge k+8; no pulse at k+11.
- Collision:
  - Stimulus: load 2 at edge k; assert preset with value 4 at edge k+3 (the expiry edge).
  - Required: no pulse at k+3; pulse at edge k+8.
- Async reset mid-count:
  - Stimulus: load 8, drive rst=0 between edges (mid-cycle), release 3 cycles later.
  - Required: time_out stays 0, no later pulse; a fresh load of 1 then pulses at 2 cycles after its load edge.

Source files
------------

// File: rtl/simple_timer.sv
// rtl/simple_timer.sv - programmable one-shot down-counting timer
//
// Purpose: a preset strobe loads a count value. The block then counts down one step
//          per clock. When the interval expires, time_out pulses high for a single cycle.
//          A load of N at edge k produces the pulse at edge k+N+1.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   preset     - load strobe, sampled on posedge; each high edge reloads
//   preset_val - count value taken when preset is high
//   time_out   - registered one-cycle expiry pulse
module simple_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             preset,
   input  logic [WIDTH-1:0] preset_val,
   output logic             time_out
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             time_out_q, time_out_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         time_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         time_out_q <= time_out_d;
      end
   end

   // A load overrides everything on its edge, including an expiry on that same edge.
   // Otherwise the counter holds at zero for one extra edge, and the pulse is raised
   // on that edge. That extra edge gives the N+1 cycle delay.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      time_out_d = 1'b0;
      if (preset) begin
         count_d = preset_val;
         state_d = COUNT;
      end else begin
         case (state_q)
            COUNT: begin
               if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
               end else begin
                  time_out_d = 1'b1;
                  state_d    = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign time_out = time_out_q;

endmodule

// File: tb/tb_simple_timer.sv
// tb/tb_simple_timer.sv - self-checking bench for simple_timer
module tb_simple_timer;

   logic       clk;
   logic       rst;
   logic       preset;
   logic [7:0] preset_val;
   logic       time_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: absolute edge number at which the pulse must appear.
   longint edge_n   = 0;
   longint deadline = -1;
   bit     exp_to   = 1'b0;

   // Observed pulses.
   int     pulse_cnt  = 0;
   longint pulse_edge = -1;
   bit     prev_to    = 1'b0;

   simple_timer #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .preset     (preset),
      .preset_val (preset_val),
      .time_out   (time_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         deadline = -1;
         exp_to   = 1'b0;
      end else begin
         edge_n = edge_n + 1;
         if (preset) begin
            deadline = edge_n + longint'(preset_val) + 1;
            exp_to   = 1'b0;
         end else if (edge_n == deadline) begin
            exp_to   = 1'b1;
            deadline = -1;
         end else begin
            exp_to   = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("time_out", longint'(time_out), longint'(exp_to));
      check("no_double_pulse", longint'(time_out & prev_to), 0);
      prev_to = time_out;
      if (time_out) begin
         pulse_cnt++;
         pulse_edge = edge_n;
      end
   end

   task automatic drive(input bit p, input logic [7:0] v);
      preset     = p;
      preset_val = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
   endtask

   initial begin
      longint k;
      int     p0;
      int     r;

      rst        = 1'b0;
      preset     = 1'b0;
      preset_val = 8'h00;

      // Reset held with preset toggling.
      for (int i = 0; i < 5; i++) drive(i[0], 8'(i + 1));
      check("reset_out", longint'(time_out), 0);
      rst = 1'b1;
      idle(10);
      check("reset_no_pulse", pulse_cnt, 0);

      // Basic countdown of 5.
      p0 = pulse_cnt;
      drive(1'b1, 8'd5); k = edge_n;
      idle(10);
      check("basic_edge", pulse_edge, k + 6);
      check("basic_cnt", pulse_cnt - p0, 1);

      // Zero value.
      p0 = pulse_cnt;
      drive(1'b1, 8'd0); k = edge_n;
      idle(4);
      check("zero_edge", pulse_edge, k + 1);
      check("zero_cnt", pulse_cnt - p0, 1);

      // Full range.
      p0 = pulse_cnt;
      drive(1'b1, 8'd255); k = edge_n;
      idle(260);
      check("max_edge", pulse_edge, k + 256);
      check("max_cnt", pulse_cnt - p0, 1);

      // Restart mid-count.
      p0 = pulse_cnt;
      drive(1'b1, 8'd10); k = edge_n;
      idle(3);
      drive(1'b1, 8'd3);
      idle(15);
      check("restart_edge", pulse_edge, k + 8);
      check("restart_cnt", pulse_cnt - p0, 1);

      // Load colliding with the expiry edge.
      p0 = pulse_cnt;
      drive(1'b1, 8'd2); k = edge_n;
      idle(2);
      drive(1'b1, 8'd4);
      idle(10);
      check("collide_edge", pulse_edge, k + 8);
      check("collide_cnt", pulse_cnt - p0, 1);

      // Load on the edge that ends a pulse.
      p0 = pulse_cnt;
      drive(1'b1, 8'd0); k = edge_n;
      idle(1);
      drive(1'b1, 8'd3);
      idle(8);
      check("pulse_load_edge", pulse_edge, k + 6);
      check("pulse_load_cnt", pulse_cnt - p0, 2);

      // Asynchronous reset clears a live pulse immediately.
      drive(1'b1, 8'd0);
      idle(1);
      check("pulse_before_rst", longint'(time_out), 1);
      #2 rst = 1'b0;
      #1 check("rst_kills_pulse", longint'(time_out), 0);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #1;

      // Reset mid-count, then a fresh load of 1.
      p0 = pulse_cnt;
      drive(1'b1, 8'd8);
      idle(2);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      idle(20);
      check("rst_mid_no_pulse", pulse_cnt - p0, 0);
      drive(1'b1, 8'd1); k = edge_n;
      idle(5);
      check("after_rst_edge", pulse_edge, k + 2);
      check("after_rst_cnt", pulse_cnt - p0, 1);

      // Randomised traffic checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            #2 rst = 1'b0;
            @(posedge clk);
            #2 rst = 1'b1;
            @(posedge clk); #1;
         end else if (r < 14) begin
            drive(1'b1, (r < 4) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12)));
         end else begin
            drive(1'b0, 8'($urandom));
         end
      end
      idle(300);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
